// File: rtl/mat_mult_seq.sv
// Sequential signed matrix multiplier: o_mat_out (MxN) = i_mat_a (MxK) * i_mat_b (KxN), N MAC lanes.
// Latency M*K cycles from the accepted-start edge to o_done; one job per M*K+1 cycles back-to-back.
// No backpressure: i_start is ignored while busy and accepted in IDLE or in the single DONE cycle.
//
// Ports:
//   i_clk       rising-edge clock
//   i_reset     synchronous active-high reset; aborts any job in flight
//   i_start     job request, sampled only in IDLE or DONE
//   i_mat_a     [M][K] x DW signed operand A, captured on an accepted start
//   i_mat_b     [K][N] x DW signed operand B, captured on an accepted start
//   o_busy      high while the job is accumulating (MAC state)
//   o_done      one-cycle pulse, o_mat_out/o_overflow were just updated
//   o_mat_out   [M][N] x ACC_W signed result, held until the next done
//   o_overflow  some element overflowed ACC_W during the last job
module mat_mult_seq #(
  parameter int M     = 2,
  parameter int K     = 2,
  parameter int N     = 2,
  parameter int DW    = 8,
  parameter int ACC_W = 32,
  parameter int SAT   = 0
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_start,
  input  logic [M-1:0][K-1:0][DW-1:0]         i_mat_a,
  input  logic [K-1:0][N-1:0][DW-1:0]         i_mat_b,
  output logic                                o_busy,
  output logic                                o_done,
  output logic [M-1:0][N-1:0][ACC_W-1:0]      o_mat_out,
  output logic                                o_overflow
);

  // A full-precision product must fit the accumulator, otherwise a single
  // term could already be truncated before the overflow check sees it.
  if (ACC_W < 2*DW) begin : g_bad_acc_w
    $error("mat_mult_seq: ACC_W (%0d) must be >= 2*DW (%0d)", ACC_W, 2*DW);
  end
  if (M < 1 || K < 1 || N < 1) begin : g_bad_dims
    $error("mat_mult_seq: M, K and N must all be >= 1");
  end

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = 2*DW;

  localparam logic [IW-1:0]    I_LAST  = IW'(M-1);
  localparam logic [KW-1:0]    K_LAST  = KW'(K-1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Operand copies: the job only ever looks at what was present at start.
  logic [M-1:0][K-1:0][DW-1:0]    r_a;
  logic [K-1:0][N-1:0][DW-1:0]    r_b;
  logic [IW-1:0]                  r_i;
  logic [KW-1:0]                  r_k;
  logic [N-1:0][ACC_W-1:0]        r_acc;
  logic [M-1:0][N-1:0][ACC_W-1:0] r_buf;
  logic [M-1:0][N-1:0][ACC_W-1:0] r_out;
  logic                           r_ovf_job;
  logic                           r_ovf;

  logic [PW-1:0]                  w_prod [N];
  logic [ACC_W:0]                 w_sum  [N];
  logic [N-1:0][ACC_W-1:0]        w_acc_nxt;
  logic [N-1:0]                   w_lane_ovf;
  logic [M-1:0][N-1:0][ACC_W-1:0] w_buf_nxt;
  logic                           w_row_end;
  logic                           w_last;
  logic                           w_accept;
  logic                           w_job_ovf;

  assign w_row_end = (r_k == K_LAST);
  assign w_last    = w_row_end && (r_i == I_LAST);
  assign w_job_ovf = r_ovf_job | (|w_lane_ovf);

  // ---------------------------------------------------------------------
  // MAC lanes. The sum is one bit wider than the accumulator so that an
  // out-of-range result shows up as a disagreement between the top two bits.
  // ---------------------------------------------------------------------
  always_comb begin
    w_acc_nxt  = '0;
    w_lane_ovf = '0;
    for (int j = 0; j < N; j++) begin
      w_prod[j] = '0;
      w_sum[j]  = '0;
    end
    for (int j = 0; j < N; j++) begin
      w_prod[j] = $signed(r_a[r_i][r_k]) * $signed(r_b[r_k][j]);
      w_sum[j]  = {r_acc[j][ACC_W-1], r_acc[j]}
                + {{(ACC_W+1-PW){w_prod[j][PW-1]}}, w_prod[j]};
      w_lane_ovf[j] = w_sum[j][ACC_W] ^ w_sum[j][ACC_W-1];
      if (w_lane_ovf[j] && (SAT != 0)) begin
        // Sign of the wide sum tells which rail was crossed.
        w_acc_nxt[j] = w_sum[j][ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
        w_acc_nxt[j] = w_sum[j][ACC_W-1:0];
      end
    end
  end

  // Row i of the buffer as it will look after this edge. On the final edge
  // the output register loads from here so the last row is not a cycle late.
  always_comb begin
    w_buf_nxt      = r_buf;
    w_buf_nxt[r_i] = w_acc_nxt;
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_MAC;
          w_accept    = 1'b1;
        end
      end
      S_MAC: begin
        o_busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_done = 1'b1;
        if (i_start) begin
          w_state_nxt = S_MAC;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_i       <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      r_buf     <= '0;
      r_out     <= '0;
      r_ovf_job <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_a       <= i_mat_a;
      r_b       <= i_mat_b;
      r_i       <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      r_ovf_job <= 1'b0;
    end else if (r_state == S_MAC) begin
      r_ovf_job <= w_job_ovf;
      if (w_row_end) begin
        r_buf <= w_buf_nxt;
        r_acc <= '0;
        r_k   <= '0;
        r_i   <= w_last ? '0 : r_i + 1'b1;
      end else begin
        r_acc <= w_acc_nxt;
        r_k   <= r_k + 1'b1;
      end
      if (w_last) begin
        r_out <= w_buf_nxt;
        r_ovf <= w_job_ovf;
      end
    end
  end

  assign o_mat_out  = r_out;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_mat_mult_seq.sv
// Bench for mat_mult_seq: four instances (default, 2x3x4, 16-bit saturate, 16-bit wrap)
// checked against a plain-arithmetic reference model of the matrix product.
// Directed steps first, then randomized jobs on every instance.
module tb_mat_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] st;
  wire  [3:0] bs, dn, ov;

  logic [1:0][1:0][7:0]  a0, b0, a2, b2, a3, b3;
  logic [1:0][2:0][7:0]  a1;
  logic [2:0][3:0][7:0]  b1;
  wire  [1:0][1:0][31:0] o0;
  wire  [1:0][3:0][31:0] o1;
  wire  [1:0][1:0][15:0] o2, o3;

  mat_mult_seq u_dut (
    .i_clk(clk), .i_reset(rst), .i_start(st[0]), .i_mat_a(a0), .i_mat_b(b0),
    .o_busy(bs[0]), .o_done(dn[0]), .o_mat_out(o0), .o_overflow(ov[0]));

  mat_mult_seq #(.M(2), .K(3), .N(4)) u_dut_234 (
    .i_clk(clk), .i_reset(rst), .i_start(st[1]), .i_mat_a(a1), .i_mat_b(b1),
    .o_busy(bs[1]), .o_done(dn[1]), .o_mat_out(o1), .o_overflow(ov[1]));

  mat_mult_seq #(.ACC_W(16), .SAT(1)) u_dut_sat (
    .i_clk(clk), .i_reset(rst), .i_start(st[2]), .i_mat_a(a2), .i_mat_b(b2),
    .o_busy(bs[2]), .o_done(dn[2]), .o_mat_out(o2), .o_overflow(ov[2]));

  mat_mult_seq #(.ACC_W(16), .SAT(0)) u_dut_wrap (
    .i_clk(clk), .i_reset(rst), .i_start(st[3]), .i_mat_a(a3), .i_mat_b(b3),
    .o_busy(bs[3]), .o_done(dn[3]), .o_mat_out(o3), .o_overflow(ov[3]));

  // Per-instance shape: rows, inner dim, cols, result width, saturate.
  int PM [4] = '{2, 2, 2, 2};
  int PK [4] = '{2, 3, 2, 2};
  int PN [4] = '{2, 4, 2, 2};
  int PW [4] = '{32, 32, 16, 16};
  int PS [4] = '{0, 0, 1, 0};

  int     ta [2][3];
  int     tbm[3][4];
  longint ex [2][4];
  longint got[2][4];
  bit     ex_ov;
  int     checks = 0;
  int     passes = 0;
  int     fails  = 0;
  int     lat;
  int     seen;

  task automatic chk(input string tag, input longint g, input longint e);
    checks++;
    assert (g === e) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, g, e);
    end
  endtask

  function automatic int rnd8(input bit extreme);
    if (extreme && ($urandom_range(0, 2) == 0)) return -128;
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic rand_ops(input bit extreme);
    for (int i = 0; i < 2; i++) for (int k = 0; k < 3; k++) ta[i][k] = rnd8(extreme);
    for (int k = 0; k < 3; k++) for (int j = 0; j < 4; j++) tbm[k][j] = rnd8(extreme);
  endtask

  task automatic apply_ops();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 3; k++) begin
        a1[i][k] = ta[i][k][7:0];
        if (k < 2) begin
          a0[i][k] = ta[i][k][7:0];
          a2[i][k] = ta[i][k][7:0];
          a3[i][k] = ta[i][k][7:0];
        end
      end
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 4; j++) begin
        b1[k][j] = tbm[k][j][7:0];
        if (k < 2 && j < 2) begin
          b0[k][j] = tbm[k][j][7:0];
          b2[k][j] = tbm[k][j][7:0];
          b3[k][j] = tbm[k][j][7:0];
        end
      end
  endtask

  // Reference: dot products accumulated term by term, each partial sum
  // either clamped to or wrapped into the signed W-bit range.
  task automatic model(input int sel);
    longint mx, mn, md, acc, s, t;
    mx = (longint'(1) <<< (PW[sel] - 1)) - 1;
    mn = -(longint'(1) <<< (PW[sel] - 1));
    md = longint'(1) <<< PW[sel];
    ex_ov = 1'b0;
    for (int i = 0; i < PM[sel]; i++)
      for (int j = 0; j < PN[sel]; j++) begin
        acc = 0;
        for (int k = 0; k < PK[sel]; k++) begin
          s = acc + longint'(ta[i][k]) * longint'(tbm[k][j]);
          if (s > mx || s < mn) begin
            ex_ov = 1'b1;
            if (PS[sel] != 0) acc = (s > mx) ? mx : mn;
            else begin
              t = (s - mn) % md;
              if (t < 0) t = t + md;
              acc = t + mn;
            end
          end else acc = s;
        end
        ex[i][j] = acc;
      end
  endtask

  task automatic grab(input int sel);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++) begin
        got[i][j] = 0;
        case (sel)
          0: if (j < 2) got[i][j] = longint'($signed(o0[i][j]));
          1: got[i][j] = longint'($signed(o1[i][j]));
          2: if (j < 2) got[i][j] = longint'($signed(o2[i][j]));
          default: if (j < 2) got[i][j] = longint'($signed(o3[i][j]));
        endcase
      end
  endtask

  task automatic compare(input int sel, input string tag);
    grab(sel);
    for (int i = 0; i < PM[sel]; i++)
      for (int j = 0; j < PN[sel]; j++)
        chk($sformatf("%s_out[%0d][%0d]", tag, i, j), got[i][j], ex[i][j]);
    chk({tag, "_ovf"}, longint'(ov[sel]), longint'(ex_ov));
  endtask

  task automatic start_job(input int sel);
    @(negedge clk);
    st[sel] = 1'b1;
    @(posedge clk);
    #1;
    st[sel] = 1'b0;
  endtask

  // Edges counted after the current point until done; -1 if it never comes.
  task automatic wait_done(input int sel, output int n);
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (dn[sel]) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic run_job(input int sel, input string tag);
    int n;
    apply_ops();
    model(sel);
    start_job(sel);
    wait_done(sel, n);
    chk({tag, "_latency"}, n, PM[sel] * PK[sel]);
    compare(sel, tag);
    @(posedge clk);
    #1;
    chk({tag, "_done_width"}, longint'(dn[sel]), 0);
  endtask

  initial begin
    st  = '0;
    rst = 1'b1;
    rand_ops(1'b0);
    apply_ops();

    // 1: reset with random inputs
    for (int c = 0; c < 2; c++) begin
      st = 4'($urandom_range(0, 15));
      @(posedge clk);
    end
    #1;
    chk("rst_busy", longint'(bs), 0);
    chk("rst_done", longint'(dn), 0);
    chk("rst_ovf",  longint'(ov), 0);
    for (int s = 0; s < 4; s++) begin
      grab(s);
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 4; j++)
          chk($sformatf("rst_out%0d[%0d][%0d]", s, i, j), got[i][j], 0);
    end
    @(negedge clk);
    st  = '0;
    rst = 1'b0;

    // 2: identity times B
    ta  = '{'{1, 0, 0}, '{0, 1, 0}};
    tbm = '{'{1, 2, 0, 0}, '{3, 4, 0, 0}, '{0, 0, 0, 0}};
    run_job(0, "ident");
    chk("ident_literal", got[1][1], 4);

    // 3: non-square 2x3 * 3x4
    ta  = '{'{1, 2, 3}, '{4, 5, 6}};
    tbm = '{'{1, 0, -1, 2}, '{0, 1, 1, 0}, '{2, -1, 0, 1}};
    run_job(1, "rect");
    chk("rect_literal", got[1][3], 14);

    // 4: all -128 into a 16-bit accumulator, saturating and wrapping
    for (int i = 0; i < 2; i++) for (int k = 0; k < 3; k++) ta[i][k] = -128;
    for (int k = 0; k < 3; k++) for (int j = 0; j < 4; j++) tbm[k][j] = -128;
    run_job(2, "sat");
    chk("sat_literal", got[0][0], 32767);
    run_job(3, "wrap");
    chk("wrap_literal", got[0][0], -32768);

    // 5: start mid-job ignored, then start held in the DONE cycle
    ta  = '{'{1, 0, 0}, '{0, 1, 0}};
    tbm = '{'{1, 2, 0, 0}, '{3, 4, 0, 0}, '{0, 0, 0, 0}};
    apply_ops();
    model(0);
    start_job(0);
    @(negedge clk);
    rand_ops(1'b0);
    apply_ops();
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    chk("ign_busy", longint'(bs[0]), 1);
    wait_done(0, lat);
    chk("ign_latency", lat, 3);
    compare(0, "ign");
    rand_ops(1'b0);
    apply_ops();
    model(0);
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    chk("b2b_busy", longint'(bs[0]), 1);
    chk("b2b_done_low", longint'(dn[0]), 0);
    wait_done(0, lat);
    chk("b2b_gap", lat + 1, 5);
    compare(0, "b2b");

    // 6: reset two cycles into a job
    rand_ops(1'b0);
    apply_ops();
    start_job(0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_busy", longint'(bs[0]), 0);
    chk("abort_done", longint'(dn[0]), 0);
    chk("abort_ovf",  longint'(ov[0]), 0);
    grab(0);
    chk("abort_out00", got[0][0], 0);
    chk("abort_out11", got[1][1], 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (dn[0]) seen++;
    end
    chk("abort_no_done", seen, 0);
    rand_ops(1'b0);
    run_job(0, "fresh");

    // Randomized jobs on every instance, extreme values on the 16-bit ones
    for (int r = 0; r < 24; r++) begin
      rand_ops(r % 4 >= 2);
      run_job(r % 4, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
